mbimager_ddr: RTL and testbench
===============================

MBIMAGER_DDR -- requirements
Module: mbimager_ddr

Interface
REQ-001 c3_sys_clk  in  1  sole clock; all logic rising-edge.
REQ-002 c3_sys_rst_i  in  1  asynchronous, active-high reset.
REQ-003 ctrl_wi  in  16  wire-in 0x00: bit0 soft reset, bit2 read request, bit3 write request, other bits ignored.
REQ-004 led_cfg_wi  in  16  wire-in 0x01; bits[7:0] drive led.
REQ-005 wr_start_wi / rd_start_wi / stop_wi  in  16 each  wire-ins 0x02/0x03/0x04: write start, read start, common stop byte address (exclusive).
REQ-006 trig40 / trig41  in  1 each  one-cycle trigger-in 0x40 bit0 (start write), 0x41 bit0 (reset pipe-in pointer).
REQ-007 pi_write, pi_data  in  1, 16  pipe-in 0x80 word strobe and data.
REQ-008 po_read  in  1; po_data  out  16  pipe-out 0xA0 word strobe and data.
REQ-009 trig60  out  1  one-cycle pulse on trigger-out 0x60 bit0 (write done).
REQ-010 wo30  out  32  status wire-out 0x30.
REQ-011 led  out  8  active-low: led = ~led_cfg_wi[7:0].
REQ-012 Memory-controller user port: calib_done in 1; cmd_en out 1, cmd_instr out 3 (000 write, 001 read), cmd_byte_addr out 30, cmd_bl out 6 (words-1), cmd_full in 1; wr_en out 1, wr_data out 32, wr_mask out 4, wr_full in 1; rd_en out 1, rd_data in 32, rd_empty in 1.

Function
REQ-013 Pipe-in buffer: 32x16; each pi_write stores pi_data at pointer, pointer increments, saturates at 32; trig41 clears pointer to 0.
REQ-014 Write job: starts on trig40 only when ctrl_wi[3]=1, state IDLE, calib_done=1; otherwise trig40 ignored.
REQ-015 Length L = stop_wi - start (bytes), bits[1:0] forced 0, clamped to 64; L=0 or stop<=start -> job completes immediately (done pulse, no memory traffic).
REQ-016 Write FSM: IDLE -> WR_DATA (push L/4 words, wr_en only when !wr_full; word n = {buf[2n+1], buf[2n]}, wr_mask=0) -> WR_CMD (cmd_en one cycle when !cmd_full, cmd_instr=000, cmd_byte_addr={14'b0,wr_start_wi[15:2],2'b00}, cmd_bl=L/4-1) -> WR_DONE (trig60 pulse 1 cycle, set wr_done flag) -> IDLE.
REQ-017 Read job: starts on rising edge of ctrl_wi[2] when state IDLE and calib_done=1; a rising edge during a busy state is held pending and serviced on return to IDLE.
REQ-018 Read FSM: IDLE -> RD_CMD (cmd_en when !cmd_full, cmd_instr=001, addr from rd_start_wi, bl=L/4-1) -> RD_DATA (rd_en when !rd_empty, each word split into two 16-bit entries, low half first, pushed to 32x16 read FIFO) -> IDLE after L/4 words; set rd_done flag.
REQ-019 Read FIFO: po_data shows head combinationally; po_read pops; po_read when empty returns 0x0000 and is ignored; overflow impossible by REQ-015 clamp.
REQ-020 wo30: [0] calib_done, [1] busy (state != IDLE), [2] wr_done flag, [3] rd_done flag, [10:4] 0, [18:11] read-FIFO byte count (2 x entries, 0..64), [31:19] 0.
REQ-021 Start values (addresses, L) latched at job start; wire-in changes mid-job have no effect.
REQ-022 wr_done cleared at next write start; rd_done cleared at next read start.
REQ-023 Simultaneous trig40 and read edge in IDLE: write takes priority, read becomes pending.
REQ-024 Only one memory command outstanding; no command issued while calib_done=0.

Reset
REQ-025 c3_sys_rst_i (async) or ctrl_wi[0]=1 (synchronous, same effect while held): FSM IDLE, pointers/counts 0, FIFOs empty, flags 0, pending read 0, trig60=0, all memory-port strobes 0; pipe-in buffer contents need not clear.
REQ-026 Reset mid-job aborts immediately; no trig60 pulse.

Verification
REQ-027 Reset, wi02=0x0010, wi03=0x0010, wi04=0x0050, wi00 bit3 set, trig41, 32 random pipe-in words, trig40 -> 16 wr_en words, one write cmd addr 0x10 bl=15, one trig60 pulse.
REQ-028 Then wi00 bit2 rising -> read cmd addr 0x10 bl=15; wo30[18:11] reaches 64; 32 po_read words match written data byte-for-byte.
REQ-029 trig40 with wi00 bit3=0 -> no memory traffic, no trig60.
REQ-030 wi04=wi02 -> trig40 yields trig60 within 3 cycles, no cmd_en.
REQ-031 Hold cmd_full/wr_full/rd_empty high for 20 cycles mid-job -> strobes stay 0, job resumes, data intact.
REQ-032 Assert c3_sys_rst_i during RD_DATA -> wo30 = {..,calib_done} with byte count 0, busy 0 immediately.

Source files
------------

// File: rtl/mbimager_ddr.sv
// mbimager_ddr: host pipe/wire bridge moving up to 64-byte bursts between a
// pipe-in buffer, a DDR user port and a pipe-out read FIFO.
module mbimager_ddr (
  input  logic        c3_sys_clk,
  input  logic        c3_sys_rst_i,
  input  logic [15:0] ctrl_wi,
  input  logic [15:0] led_cfg_wi,
  input  logic [15:0] wr_start_wi,
  input  logic [15:0] rd_start_wi,
  input  logic [15:0] stop_wi,
  input  logic        trig40,
  input  logic        trig41,
  input  logic        pi_write,
  input  logic [15:0] pi_data,
  input  logic        po_read,
  output logic [15:0] po_data,
  output logic        trig60,
  output logic [31:0] wo30,
  output logic [7:0]  led,
  input  logic        calib_done,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [29:0] cmd_byte_addr,
  output logic [5:0]  cmd_bl,
  input  logic        cmd_full,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic        wr_full,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty
);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, WR_DONE, RD_CMD, RD_DATA} state_t;
  state_t      r_state;
  logic [15:0] r_pbuf [32];
  logic [15:0] r_fifo [32];
  logic [5:0]  r_pptr, r_fcnt;
  logic [4:0]  r_fwp, r_frp, r_nw;
  logic [3:0]  r_cnt;
  logic [29:0] r_addr;
  logic        r_trig60, r_wr_done, r_rd_done, r_pend, r_c2;
  logic        w_srst, w_idle, w_redge, w_wstart, w_rstart, w_last, w_pop, w_unused;
  logic [4:0]  w_wwords, w_rwords;

  // Burst length in 32-bit words: byte span floored to words, capped at 16.
  function automatic logic [4:0] f_words(input logic [15:0] s, input logic [15:0] e);
    logic [15:0] d;
    d = e - s;
    return (e <= s) ? 5'd0 : (d >= 16'd64) ? 5'd16 : d[6:2];
  endfunction

  assign w_srst   = ctrl_wi[0];
  assign w_idle   = r_state == IDLE;
  assign w_redge  = ctrl_wi[2] & ~r_c2;
  assign w_wstart = trig40 & ctrl_wi[3] & w_idle & calib_done;
  assign w_rstart = (w_redge | r_pend) & w_idle & calib_done & ~w_wstart;
  assign w_wwords = f_words(wr_start_wi, stop_wi);
  assign w_rwords = f_words(rd_start_wi, stop_wi);
  assign w_last   = {1'b0, r_cnt} == r_nw - 5'd1;
  assign w_pop    = po_read & (r_fcnt != 6'd0);
  assign w_unused = ^{ctrl_wi[15:4], ctrl_wi[1], led_cfg_wi[15:8]};

  assign cmd_en        = ~w_srst & calib_done & ~cmd_full & (r_state == WR_CMD | r_state == RD_CMD);
  assign wr_en         = ~w_srst & ~wr_full & (r_state == WR_DATA);
  assign rd_en         = ~w_srst & ~rd_empty & (r_state == RD_DATA);
  assign cmd_instr     = {2'b00, r_state == RD_CMD};
  assign cmd_byte_addr = r_addr;
  assign cmd_bl        = {1'b0, r_nw - 5'd1};
  assign wr_data       = {r_pbuf[{r_cnt, 1'b1}], r_pbuf[{r_cnt, 1'b0}]};
  assign wr_mask       = 4'h0;
  assign po_data       = (r_fcnt != 6'd0) ? r_fifo[r_frp] : 16'h0000;
  assign wo30          = {13'b0, 1'b0, r_fcnt, 1'b0, 7'b0, r_rd_done, r_wr_done, ~w_idle, calib_done};
  assign trig60        = r_trig60;
  assign led           = ~led_cfg_wi[7:0];

  always_ff @(posedge c3_sys_clk) begin
    if (pi_write & ~r_pptr[5]) r_pbuf[r_pptr[4:0]] <= pi_data;
    if (rd_en) begin
      r_fifo[r_fwp]        <= rd_data[15:0];
      r_fifo[r_fwp + 5'd1] <= rd_data[31:16];
    end
  end

  always_ff @(posedge c3_sys_clk or posedge c3_sys_rst_i) begin
    if (c3_sys_rst_i) begin
      r_pptr <= '0; r_fwp <= '0; r_frp <= '0; r_fcnt <= '0;
    end else if (w_srst) begin
      r_pptr <= '0; r_fwp <= '0; r_frp <= '0; r_fcnt <= '0;
    end else begin
      r_pptr <= trig41 ? 6'd0 : r_pptr + {5'b0, pi_write & ~r_pptr[5]};
      r_fwp  <= r_fwp + {3'b0, rd_en, 1'b0};
      r_frp  <= r_frp + {4'b0, w_pop};
      r_fcnt <= r_fcnt + {4'b0, rd_en, 1'b0} - {5'b0, w_pop};
    end
  end

  always_ff @(posedge c3_sys_clk or posedge c3_sys_rst_i) begin
    if (c3_sys_rst_i) begin
      r_state <= IDLE; r_nw <= '0; r_cnt <= '0; r_addr <= '0;
      r_trig60 <= 1'b0; r_wr_done <= 1'b0; r_rd_done <= 1'b0; r_pend <= 1'b0; r_c2 <= 1'b0;
    end else if (w_srst) begin
      r_state <= IDLE; r_nw <= '0; r_cnt <= '0; r_addr <= '0;
      r_trig60 <= 1'b0; r_wr_done <= 1'b0; r_rd_done <= 1'b0; r_pend <= 1'b0; r_c2 <= ctrl_wi[2];
    end else begin
      r_c2     <= ctrl_wi[2];
      r_trig60 <= 1'b0;
      r_pend   <= ~w_rstart & (r_pend | w_redge);
      case (r_state)
        IDLE:
          if (w_wstart) begin
            r_nw      <= w_wwords;
            r_addr    <= {14'b0, wr_start_wi[15:2], 2'b00};
            r_cnt     <= '0;
            r_wr_done <= 1'b0;
            r_state   <= (w_wwords == 5'd0) ? WR_DONE : WR_DATA;
          end else if (w_rstart) begin
            r_nw      <= w_rwords;
            r_addr    <= {14'b0, rd_start_wi[15:2], 2'b00};
            r_cnt     <= '0;
            r_rd_done <= w_rwords == 5'd0;
            r_state   <= (w_rwords == 5'd0) ? IDLE : RD_CMD;
          end
        WR_DATA:
          if (wr_en) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_last) r_state <= WR_CMD;
          end
        WR_CMD:
          if (cmd_en) r_state <= WR_DONE;
        WR_DONE: begin
          r_trig60  <= 1'b1;
          r_wr_done <= 1'b1;
          r_state   <= IDLE;
        end
        RD_CMD:
          if (cmd_en) r_state <= RD_DATA;
        RD_DATA:
          if (rd_en) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
              r_rd_done <= 1'b1;
              r_state   <= IDLE;
            end
          end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbimager_ddr.sv
// tb_mbimager_ddr: scoreboard bench with a behavioural DDR user-port model.
module tb_mbimager_ddr;
  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] ctrl_wi = 0, led_cfg_wi = 16'h00A5, wr_start_wi = 0, rd_start_wi = 0, stop_wi = 0;
  logic        trig40 = 0, trig41 = 0, pi_write = 0, po_read = 0;
  logic [15:0] pi_data = 0, po_data;
  logic        trig60;
  logic [31:0] wo30;
  logic [7:0]  led;
  logic        calib_done = 1'b1, cmd_en, cmd_full = 0, wr_en, wr_full = 0, rd_en, rd_empty;
  logic [2:0]  cmd_instr;
  logic [29:0] cmd_byte_addr;
  logic [5:0]  cmd_bl;
  logic [31:0] wr_data, rd_data = 0;
  logic [3:0]  wr_mask;
  logic        rd_e = 1'b1, stall_rd = 1'b0;

  int total = 0, bad = 0, etrig = 0, ntrig = 0;
  logic [63:0] ecmd[$], ewr[$], epo[$];
  logic [31:0] wq[$], rq[$];
  logic [31:0] mem [int];
  logic [15:0] pin [64];

  assign rd_empty = rd_e | stall_rd;

  mbimager_ddr dut (
    .c3_sys_clk(clk), .c3_sys_rst_i(rst), .ctrl_wi(ctrl_wi), .led_cfg_wi(led_cfg_wi),
    .wr_start_wi(wr_start_wi), .rd_start_wi(rd_start_wi), .stop_wi(stop_wi),
    .trig40(trig40), .trig41(trig41), .pi_write(pi_write), .pi_data(pi_data),
    .po_read(po_read), .po_data(po_data), .trig60(trig60), .wo30(wo30), .led(led),
    .calib_done(calib_done), .cmd_en(cmd_en), .cmd_instr(cmd_instr),
    .cmd_byte_addr(cmd_byte_addr), .cmd_bl(cmd_bl), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic load(input int base, input bit extra);
    trig41 = 1; tick; trig41 = 0;
    pi_write = 1;
    for (int i = 0; i < 32; i++) begin pi_data = pin[base + i]; tick; end
    if (extra) begin pi_data = 16'hDEAD; tick; end
    pi_write = 0;
  endtask

  task automatic exp_cmd(input logic [2:0] ins, input logic [29:0] a);
    ecmd.push_back(64'({ins, a, 6'd15}));
  endtask

  task automatic exp_write(input int base, input logic [29:0] a);
    exp_cmd(3'b000, a);
    for (int n = 0; n < 16; n++) ewr.push_back(64'({4'h0, pin[base + 2*n + 1], pin[base + 2*n]}));
    etrig++;
  endtask

  task automatic drain(input int base);
    po_read = 1;
    for (int i = 0; i < 32; i++) begin epo.push_back(64'(pin[base + i])); tick; end
    po_read = 0;
  endtask

  // DDR user-port model: strobes sampled mid-cycle, state updated after the edge.
  initial begin
    logic ce, we, re;
    logic [2:0] ci;
    logic [29:0] ca;
    logic [5:0] cb;
    logic [31:0] wd;
    forever begin
      @(negedge clk);
      ce = cmd_en; ci = cmd_instr; ca = cmd_byte_addr; cb = cmd_bl; we = wr_en; wd = wr_data; re = rd_en;
      @(posedge clk); #1;
      if (we) wq.push_back(wd);
      if (re && rq.size() > 0) void'(rq.pop_front());
      if (ce)
        for (int i = 0; i <= int'(cb); i++)
          if (ci == 3'b000) mem[int'(ca[29:2]) + i] = (wq.size() > 0) ? wq.pop_front() : 32'h0;
          else rq.push_back(mem.exists(int'(ca[29:2]) + i) ? mem[int'(ca[29:2]) + i] : 32'h0);
      rd_e = rq.size() == 0;
      rd_data = rd_e ? 32'h0 : rq[0];
    end
  end

  always @(negedge clk) begin
    if (cmd_en) begin
      if (ecmd.size() == 0) chk("cmd_unexpected", 64'({cmd_instr, cmd_byte_addr, cmd_bl}), 64'h0);
      else chk("cmd", 64'({cmd_instr, cmd_byte_addr, cmd_bl}), ecmd.pop_front());
    end
    if (wr_en) begin
      if (ewr.size() == 0) chk("wr_unexpected", 64'(wr_data), 64'h0);
      else chk("wr_word", 64'({wr_mask, wr_data}), ewr.pop_front());
    end
    if (trig60) begin
      chk("trig60_expected", 64'(etrig > 0), 64'd1);
      if (etrig > 0) etrig--;
      ntrig++;
    end
    if (po_read) begin
      if (epo.size() == 0) chk("po_unexpected", 64'(po_data), 64'hFFFF_FFFF);
      else chk("po_data", 64'(po_data), epo.pop_front());
    end
  end

  initial begin
    int n0;
    for (int i = 0; i < 64; i++) pin[i] = 16'((i * 40503 + 23130) ^ (i << 11));
    repeat (3) tick;
    rst = 0;
    tick;
    chk("reset_wo30", 64'(wo30), 64'h1);
    chk("reset_po_data", 64'(po_data), 64'h0);
    chk("reset_strobes", 64'({trig60, cmd_en, wr_en, rd_en}), 64'h0);
    chk("led", 64'(led), 64'h5A);

    // Basic write of 64 bytes at 0x10; wire-ins changed mid-job must not matter.
    wr_start_wi = 16'h0010; rd_start_wi = 16'h0010; stop_wi = 16'h0050; ctrl_wi = 16'h0008;
    load(0, 0);
    exp_write(0, 30'h10);
    trig40 = 1; tick; trig40 = 0;
    wr_start_wi = 16'h0100; stop_wi = 16'h0104;
    for (int i = 0; i < 200 && !wo30[2]; i++) @(negedge clk);
    chk("wr_done_flag", 64'(wo30[2:1]), 64'h2);
    wr_start_wi = 16'h0010; stop_wi = 16'h0050;
    tick;

    // Read it back through the FIFO.
    exp_cmd(3'b001, 30'h10);
    ctrl_wi = 16'h000C; tick;
    for (int i = 0; i < 200 && !wo30[3]; i++) @(negedge clk);
    chk("rd_done_flag", 64'(wo30[3]), 64'h1);
    chk("fifo_bytes_full", 64'(wo30[18:11]), 64'd64);
    tick;
    drain(0);
    chk("fifo_bytes_empty", 64'(wo30[18:11]), 64'd0);
    epo.push_back(64'h0);
    po_read = 1; tick; po_read = 0;
    chk("fifo_empty_read", 64'(wo30[18:11]), 64'd0);
    ctrl_wi = 16'h0008; tick;

    // trig40 without write enable: ignored.
    ctrl_wi = 16'h0000;
    trig40 = 1; tick; trig40 = 0;
    repeat (30) tick;
    chk("ignored_trig40", 64'(wo30[3:1]), 64'h6);
    ctrl_wi = 16'h0008;

    // Zero-length write completes straight away.
    stop_wi = 16'h0010;
    etrig++;
    n0 = ntrig;
    trig40 = 1; tick; trig40 = 0;
    repeat (3) tick;
    chk("zero_len_done", 64'(ntrig - n0), 64'd1);
    chk("zero_len_flag", 64'(wo30[2:1]), 64'h2);

    // Back-pressure on every port, read edge held pending during the write,
    // and a 33rd pipe word that must not wrap the saturated pointer.
    wr_start_wi = 16'h0040; rd_start_wi = 16'h0040; stop_wi = 16'h0080;
    load(32, 1);
    exp_write(32, 30'h40);
    exp_cmd(3'b001, 30'h40);
    cmd_full = 1; wr_full = 1; stall_rd = 1;
    trig40 = 1; tick; trig40 = 0;
    ctrl_wi = 16'h000C;
    repeat (20) begin
      @(negedge clk);
      chk("stall_wr_cmd", 64'({cmd_en, wr_en}), 64'h0);
    end
    chk("stall_busy", 64'(wo30[2:1]), 64'h1);
    tick;
    cmd_full = 0; wr_full = 0;
    repeat (40) begin
      @(negedge clk);
      chk("stall_rd_en", 64'(rd_en), 64'h0);
    end
    chk("pending_read_busy", 64'({wo30[3], wo30[1]}), 64'h1);
    tick;
    stall_rd = 0;
    for (int i = 0; i < 200 && !wo30[3]; i++) @(negedge clk);
    chk("stall_rd_done", 64'(wo30[18:11]), 64'd64);
    tick;
    drain(32);
    ctrl_wi = 16'h0008; tick;

    // Asynchronous reset in the middle of a read burst.
    exp_cmd(3'b001, 30'h40);
    ctrl_wi = 16'h000C;
    for (int i = 0; i < 100 && wo30[18:11] == 8'd0; i++) @(negedge clk);
    chk("mid_read_busy", 64'(wo30[1]), 64'h1);
    rst = 1; #1;
    chk("async_reset_wo30", 64'(wo30), 64'h1);
    tick;
    ctrl_wi = 16'h0008;
    tick;
    rst = 0;
    rq.delete();
    repeat (20) tick;
    chk("after_reset_idle", 64'(wo30), 64'h1);

    chk("left_cmd", 64'(ecmd.size()), 64'd0);
    chk("left_wr", 64'(ewr.size()), 64'd0);
    chk("left_po", 64'(epo.size()), 64'd0);
    chk("left_trig", 64'(etrig), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
